// File: rtl/subleq_ctrl.sv
// SUBLEQ sequencer: fetches A/B/C, reads both operands, writes mem[B]-mem[A]
// back to mem[B] and branches to C when the result is <= 0.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_ctrl (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  run,
    input  logic [`WORD_SIZE-1:0] pc_in,
    output logic                  pc_inc,
    output logic                  pc_branch,
    output logic [`WORD_SIZE-1:0] pc_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [`WORD_SIZE-1:0] mem_addr,
    output logic [`WORD_SIZE-1:0] mem_wdata,
    input  logic [`WORD_SIZE-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  halted,
    output logic                  retired
);

    localparam int unsigned W = `WORD_SIZE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_FETCH_C,
        S_READ_A,
        S_READ_B,
        S_WRITE,
        S_BRANCH,
        S_HALT
    } state_e;

    state_e         state_q;
    logic [W-1:0]   a_q, b_q, c_q, opa_q, opb_q, ia_q;
    logic           leq_q;
    logic           mem_req_q, mem_we_q, pc_branch_q, retired_q, halted_q;
    logic [W-1:0]   mem_addr_q, mem_wdata_q, pc_addr_q;

    logic           xfer_c;
    logic           fetch_c;
    logic [W-1:0]   pc_next_d;
    logic [W-1:0]   wdata_d;
    logic [W-1:0]   diff_c;
    logic           leq_d;
    logic [W-1:0]   ia_d;

    // A transfer only completes while a request is outstanding
    assign xfer_c  = mem_req_q && mem_ack;
    assign fetch_c = (state_q == S_FETCH_A) || (state_q == S_FETCH_B) || (state_q == S_FETCH_C);
    assign pc_inc  = xfer_c && fetch_c;

    assign pc_next_d = W'(pc_in + W'(1));
    assign wdata_d   = W'(mem_rdata - opa_q);
    assign diff_c    = W'(opb_q - opa_q);
    assign leq_d     = diff_c[W-1] | (diff_c == '0);
    // PC the next instruction starts from once the branch edge has passed
    assign ia_d      = leq_q ? c_q : pc_in;

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            ia_q        <= '0;
            leq_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pc_branch_q <= 1'b0;
            pc_addr_q   <= '0;
            retired_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_branch_q <= 1'b0;
            retired_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q    <= S_FETCH_A;
                        ia_q       <= pc_in;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_in;
                    end
                end
                S_FETCH_A: begin
                    if (xfer_c) begin
                        a_q        <= mem_rdata;
                        mem_addr_q <= pc_next_d;
                        state_q    <= S_FETCH_B;
                    end
                end
                S_FETCH_B: begin
                    if (xfer_c) begin
                        b_q        <= mem_rdata;
                        mem_addr_q <= pc_next_d;
                        state_q    <= S_FETCH_C;
                    end
                end
                S_FETCH_C: begin
                    if (xfer_c) begin
                        c_q        <= mem_rdata;
                        mem_addr_q <= a_q;
                        state_q    <= S_READ_A;
                    end
                end
                S_READ_A: begin
                    if (xfer_c) begin
                        opa_q      <= mem_rdata;
                        mem_addr_q <= b_q;
                        state_q    <= S_READ_B;
                    end
                end
                S_READ_B: begin
                    // Address stays at B for the write-back
                    if (xfer_c) begin
                        opb_q       <= mem_rdata;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= wdata_d;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (xfer_c) begin
                        leq_q       <= leq_d;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        pc_branch_q <= leq_d;
                        pc_addr_q   <= c_q;
                        retired_q   <= 1'b1;
                        state_q     <= S_BRANCH;
                    end
                end
                S_BRANCH: begin
                    if (leq_q && (c_q == ia_q)) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (run) begin
                        ia_q       <= ia_d;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= ia_d;
                        state_q    <= S_FETCH_A;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc_branch = pc_branch_q;
    assign pc_addr   = pc_addr_q;
    assign retired   = retired_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: PC/memory model plus a scoreboard of expected
// memory transfers and retirements, popped by a negedge monitor.
`timescale 1ns/1ps

module tb_subleq_ctrl;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] data;
    } xfer_t;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic         run = 1'b0;
    logic [W-1:0] pc = '0;
    logic         pc_inc, pc_branch, mem_req, mem_we, mem_ack, halted, retired;
    logic [W-1:0] pc_addr, mem_addr, mem_wdata, mem_rdata;

    logic [W-1:0] mem [0:255];
    logic         ld_en = 1'b0;
    logic [7:0]   ld_addr = '0;
    logic [W-1:0] ld_data = '0;
    logic         pc_ld = 1'b0;
    logic [W-1:0] pc_ld_val = '0;
    int           wait_cfg = 0;
    int           wcnt = 0;
    logic         hold_we = 1'b0;
    logic         force_ack = 1'b0;

    xfer_t        exp_x[$];
    logic [W:0]   exp_r[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_inc = 0;
    int           n_req = 0;
    int           n_ret = 0;
    int           viol = 0;
    logic         mon_en = 1'b0;

    subleq_ctrl dut (
        .clk       (clk),
        .areset    (areset),
        .run       (run),
        .pc_in     (pc),
        .pc_inc    (pc_inc),
        .pc_branch (pc_branch),
        .pc_addr   (pc_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];
    assign mem_ack   = force_ack | (mem_req && (wcnt >= wait_cfg) && !(hold_we && mem_we));

    // PC register and word memory with programmable wait states
    always @(posedge clk) begin
        if (pc_ld)          pc <= pc_ld_val;
        else if (pc_branch) pc <= pc_addr;
        else if (pc_inc)    pc <= pc + 16'd1;
        if (ld_en)                             mem[ld_addr] <= ld_data;
        else if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else             n_pass++;
    endtask

    // Monitor: pops expectations on completed transfers and retirements
    initial begin
        logic         pw;
        logic [W-1:0] pa, pd;
        logic         pwe;
        xfer_t        e;
        logic [W:0]   r;
        pw = 1'b0; pa = '0; pd = '0; pwe = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_req && mem_ack) begin
                    if (exp_x.size() == 0) begin
                        check("xfer_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_x.pop_front();
                        check("xfer", {31'd0, mem_addr, mem_we, mem_we ? mem_wdata : 16'h0},
                              {31'd0, e.addr, e.we, e.we ? e.data : 16'h0});
                    end
                end
                if (retired) begin
                    if (exp_r.size() == 0) begin
                        check("retire_unexpected", 64'(pc_addr), 64'hFFFF_FFFF);
                    end else begin
                        r = exp_r.pop_front();
                        check("retire", 64'({pc_branch, pc_addr}), 64'(r));
                    end
                end
                if (pc_inc && pc_branch) viol++;
                if (pc_inc && !(mem_req && mem_ack)) viol++;
                if (pw && mem_req && ({mem_addr, mem_we, mem_wdata} != {pa, pwe, pd})) viol++;
                n_inc += int'(pc_inc);
                n_req += int'(mem_req);
                n_ret += int'(retired);
            end
            pw  = mem_req && !mem_ack;
            pa  = mem_addr;
            pwe = mem_we;
            pd  = mem_wdata;
        end
    end

    task automatic load(input logic [7:0] a, input logic [W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic set_pc(input logic [W-1:0] v);
        pc_ld = 1'b1; pc_ld_val = v;
        @(negedge clk);
        pc_ld = 1'b0;
    endtask

    task automatic push_x(input logic [W-1:0] a, input logic we, input logic [W-1:0] d);
        xfer_t e;
        e.addr = a; e.we = we; e.data = d;
        exp_x.push_back(e);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
    endtask

    // Pulse run for one cycle, return at the negedge of the retiring cycle
    task automatic run_one(output int cycles);
        run = 1'b1;
        @(negedge clk);
        cycles = 1;
        run = 1'b0;
        while (!retired && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"}, 64'({mem_req, mem_we, pc_inc, pc_branch, retired, halted}), 64'd0);
        check({tag, "_buses"}, {16'd0, mem_addr, mem_wdata, pc_addr}, 64'd0);
    endtask

    initial begin
        int cyc, base, k;
        logic [W-1:0] pc_save;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        do_reset();
        check_idle_outputs("reset");
        mon_en = 1'b1;

        // Non-positive result: 5 - 7 = -2, branch to 6
        load(8'd0, 16'd3); load(8'd1, 16'd4); load(8'd2, 16'd6);
        load(8'd3, 16'd7); load(8'd4, 16'd5);
        set_pc(16'd0);
        push_x(16'd0, 0, 0); push_x(16'd1, 0, 0); push_x(16'd2, 0, 0);
        push_x(16'd3, 0, 0); push_x(16'd4, 0, 0); push_x(16'd4, 1, 16'hFFFE);
        exp_r.push_back({1'b1, 16'd6});
        base = n_ret;
        run_one(cyc);
        check("neg_cycles", 64'(cyc), 64'd7);
        @(negedge clk);
        check("neg_mem4", 64'(mem[4]), 64'hFFFE);
        check("neg_pc", 64'(pc), 64'd6);
        check("neg_retired_once", 64'(n_ret - base), 64'd1);

        // Positive result: 5 - 2 = 3, fall through to PC+3
        load(8'd3, 16'd2); load(8'd4, 16'd5);
        set_pc(16'd0);
        push_x(16'd0, 0, 0); push_x(16'd1, 0, 0); push_x(16'd2, 0, 0);
        push_x(16'd3, 0, 0); push_x(16'd4, 0, 0); push_x(16'd4, 1, 16'd3);
        exp_r.push_back({1'b0, 16'd6});
        base = n_inc;
        run_one(cyc);
        @(negedge clk);
        check("pos_mem4", 64'(mem[4]), 64'd3);
        check("pos_pc", 64'(pc), 64'd3);
        check("pos_inc_count", 64'(n_inc - base), 64'd3);

        // Self-loop halt: mem[9] - mem[9] = 0, C == instruction address
        load(8'd6, 16'd9); load(8'd7, 16'd9); load(8'd8, 16'd6); load(8'd9, 16'h1234);
        set_pc(16'd6);
        push_x(16'd6, 0, 0); push_x(16'd7, 0, 0); push_x(16'd8, 0, 0);
        push_x(16'd9, 0, 0); push_x(16'd9, 0, 0); push_x(16'd9, 1, 16'd0);
        exp_r.push_back({1'b1, 16'd6});
        run_one(cyc);
        check("halt_not_yet", 64'(halted), 64'd0);
        @(negedge clk);
        check("halt_rise", 64'(halted), 64'd1);
        base = n_req;
        run = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        run = 1'b0;
        check("halt_no_req", 64'(n_req - base), 64'd0);
        check("halt_sticky", 64'(halted), 64'd1);
        check("halt_pc", 64'(pc), 64'd6);

        // Two wait states per transfer; 0x8000 - 1 wraps to positive 0x7FFF
        do_reset();
        check_idle_outputs("reset2");
        wait_cfg = 2;
        load(8'h10, 16'h0020); load(8'h11, 16'h0021); load(8'h12, 16'h0030);
        load(8'h20, 16'h0001); load(8'h21, 16'h8000);
        set_pc(16'h0010);
        push_x(16'h10, 0, 0); push_x(16'h11, 0, 0); push_x(16'h12, 0, 0);
        push_x(16'h20, 0, 0); push_x(16'h21, 0, 0); push_x(16'h21, 1, 16'h7FFF);
        exp_r.push_back({1'b0, 16'h0030});
        run_one(cyc);
        check("wait_cycles", 64'(cyc), 64'd19);
        @(negedge clk);
        check("wait_pc", 64'(pc), 64'h13);
        check("wait_mem", 64'(mem[8'h21]), 64'h7FFF);
        check("wait_invariants", 64'(viol), 64'd0);

        // Drop run during READ_A; instruction still completes, then idles
        wait_cfg = 0;
        load(8'h13, 16'h0022); load(8'h14, 16'h0023); load(8'h15, 16'h0040);
        load(8'h22, 16'd5); load(8'h23, 16'd5);
        push_x(16'h13, 0, 0); push_x(16'h14, 0, 0); push_x(16'h15, 0, 0);
        push_x(16'h22, 0, 0); push_x(16'h23, 0, 0); push_x(16'h23, 1, 16'd0);
        exp_r.push_back({1'b1, 16'h0040});
        run = 1'b1;
        k = 0;
        while (!(mem_req && !mem_we && mem_addr == 16'h22) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("runstop_reach_read_a", 64'(k < 50), 64'd1);
        run = 1'b0;
        k = 0;
        while (!retired && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("runstop_retired", 64'(retired), 64'd1);
        base = n_req;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("runstop_idle_req", 64'({mem_req, 32'(n_req - base)}), 64'd0);
        check("runstop_pc", 64'(pc), 64'h40);
        load(8'h40, 16'h0050); load(8'h41, 16'h0051); load(8'h42, 16'h0060);
        load(8'h50, 16'd3); load(8'h51, 16'd10);
        push_x(16'h40, 0, 0); push_x(16'h41, 0, 0); push_x(16'h42, 0, 0);
        push_x(16'h50, 0, 0); push_x(16'h51, 0, 0); push_x(16'h51, 1, 16'd7);
        exp_r.push_back({1'b0, 16'h0060});
        run_one(cyc);
        check("resume_cycles", 64'(cyc), 64'd7);
        @(negedge clk);
        check("resume_pc", 64'(pc), 64'h43);

        // Reset while the write is waiting for an ack that never comes
        hold_we = 1'b1;
        load(8'h43, 16'h0052); load(8'h44, 16'h0053); load(8'h45, 16'h0043);
        load(8'h52, 16'd1); load(8'h53, 16'd1);
        push_x(16'h43, 0, 0); push_x(16'h44, 0, 0); push_x(16'h45, 0, 0);
        push_x(16'h52, 0, 0); push_x(16'h53, 0, 0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        k = 0;
        while (!(mem_req && mem_we) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_write", 64'({mem_we, mem_addr, mem_wdata}), {31'd0, 1'b1, 16'h0053, 16'h0000});
        @(negedge clk);
        @(negedge clk);
        check("rst_write_held", 64'({mem_req, mem_we, mem_addr}), {46'd0, 2'b11, 16'h0053});
        do_reset();
        hold_we = 1'b0;
        check_idle_outputs("midreset");
        pc_save = pc;
        base = n_inc;
        force_ack = 1'b1;
        #1;
        check("stray_ack_inc", 64'(pc_inc), 64'd0);
        @(negedge clk);
        force_ack = 1'b0;
        check("stray_ack_pc", 64'({pc, 32'(n_inc - base)}), {16'd0, pc_save, 32'd0});
        check("stray_ack_mem", 64'(mem[8'h53]), 64'd1);

        check("scoreboard_drained", 64'({32'(exp_x.size()), 32'(exp_r.size())}), 64'd0);
        check("invariants", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/subleq_ctrl.md
# subleq_ctrl

Sequencing controller for the SUBLEQ core: runs the per-instruction fetch/execute cycle by driving the program counter's `branch`/`inc`/`addr` controls and a single-port, request/acknowledge memory. Each instruction `A B C` executes as `mem[B] <= mem[B] - mem[A]`; the next PC is `C` if the signed result is <= 0, otherwise `PC+3`. The controller sits between the PC register, the shared word memory and the top-level run/halt control.

## Interface
- `WORD_SIZE`: word width, taken from the `` `WORD_SIZE`` macro in defines.vh. No module parameters.

- `clk`  in  1  clock.
- `areset`  in  1  reset, synchronous, active-high (sampled on posedge `clk`).
- `run`  in  1  level; controller executes instructions while high.
- `pc_in`  in  `WORD_SIZE`  current PC value.
- `pc_inc`  out  1  PC increment by 1 at this edge.
- `pc_branch`  out  1  PC load from `pc_addr` at this edge.
- `pc_addr`  out  `WORD_SIZE`  branch target.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  `WORD_SIZE`  request address.
- `mem_wdata`  out  `WORD_SIZE`  write data.
- `mem_rdata`  in  `WORD_SIZE`  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  transfer completes at the edge where `mem_req && mem_ack`.
- `halted`  out  1  sticky halt flag.
- `retired`  out  1  one-cycle pulse per completed instruction.

## Operation
- States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, BRANCH, HALT.
- IDLE -> FETCH_A when `run` = 1. Registers `ia <= pc_in` (instruction address).
- FETCH_A/B/C:
  - Read request to `pc_in`.
  - On ack, latch `A`, `B` or `C` respectively.
  - `pc_inc = mem_req && mem_ack`, combinational, so the PC advances at the same edge as the ack.
- READ_A: read `mem[A]`; latch `opA`.
- READ_B: read `mem[B]`; latch `opB`.
- WRITE:
  - Write `mem[B] <= opB - opA`, modulo 2^`WORD_SIZE`.
  - On ack, register `leq = diff[MSB] | (diff == 0)`.
- BRANCH (one cycle, no memory access):
  - `pc_branch = leq`, `pc_addr = C`, `retired = 1`.
  - If `leq && C == ia`: go to HALT (self-loop halt; the branch is still issued).
  - Else if `run`: go to FETCH_A and re-register `ia`.
  - Else: go to IDLE.
- HALT: `halted = 1`. Terminal until `areset`; `run` is ignored.
- Dropping `run` mid-instruction does not stop it: the instruction completes and the controller stops at the BRANCH -> IDLE boundary.
- `mem_ack` while `mem_req` is low is ignored.
- A state with `mem_req` high waits indefinitely for an ack. `mem_addr`, `mem_we` and `mem_wdata` stay stable until the ack.

## Timing
- Reset values (the cycle after `areset` is sampled high):
  - State is IDLE.
  - `mem_req`, `mem_we`, `pc_inc`, `pc_branch`, `retired`, `halted` = 0.
  - `mem_addr`, `mem_wdata`, `pc_addr` = 0.
  - Internal registers `A`, `B`, `C`, `opA`, `opB`, `leq`, `ia` = 0.
- Reset mid-transfer abandons the request: `mem_req` is low the next cycle. The memory must tolerate this.
- With zero-wait memory (ack in the same cycle as req), an instruction takes 7 cycles (FETCH_A through BRANCH). Each memory wait cycle adds 1.
- `mem_req` is asserted in the first cycle of each memory state; there is no idle cycle between back-to-back transfers.
- `pc_inc` and `pc_branch` are never high in the same cycle.
- `pc_inc` is high exactly 3 times per instruction.
- `retired` is high exactly once per instruction, in the BRANCH cycle.
- `halted` rises in the cycle after the halting BRANCH.

## Test plan
- Non-positive result, `WORD_SIZE`=16, zero-wait memory, PC=0, mem[0..4] = 3,4,6,7,5, `run`=1:
  - mem[4] = 0xFFFE.
  - `pc_branch` pulses with `pc_addr`=6; PC=6 after 7 cycles.
  - `retired` pulses once.
- Positive result, mem[3]=2, mem[4]=5:
  - mem[4]=3.
  - `pc_branch` stays 0; PC=3 after three `pc_inc` pulses.
- Self-loop halt, PC=6, mem[6..9] = 9,9,6,x:
  - `diff`=0, so `leq`=1; branch to 6.
  - `halted`=1 and stays 1; no further `mem_req` even with `run`=1.
- Memory wait states: ack delayed 2 cycles on every transfer:
  - Instruction takes 19 cycles.
  - Address, `mem_we` and data stay stable while waiting.
  - `pc_inc` coincides only with acks.
- `run` dropped during READ_A: the write and branch complete, then the controller goes to IDLE with `mem_req`=0; raising `run` resumes from the new PC.
- `areset` during WRITE with ack withheld:
  - Next cycle: `mem_req`=0, state IDLE, all outputs 0.
  - A stray `mem_ack` afterwards causes no `pc_inc`.
